// File: rtl/ipd_ibuf_stage.sv
// ipd_ibuf_stage: multi-issue pre-decode stage with a circular instruction buffer.
//
// Takes up to FETCH_W instructions per cycle from IF and decodes each one into a
// one-hot type vector, register numbers and an extended immediate. The decoded
// entries are stored in a DEPTH-entry ring. The head entry goes to ID one per
// cycle under a valid/allow_in handshake. br_taken_cancel flushes the ring.
//
// Optional feature, macro IPD_BYPASS_EN: when the ring is empty, slot 0 of an
// incoming packet is presented to ID in the same cycle. Without the macro the
// latency is one cycle and no if_* input reaches an ipd_* output combinationally.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   if_to_ipd_valid   fetch packet valid
//   if_pc             PC of slot 0 (slot i PC = if_pc + 4*i)
//   if_pred_pc        predicted next PC after the last valid slot
//   if_inst           FETCH_W instruction words, slot i at [32*i+31:32*i]
//   if_slot_mask      per-slot valid bits
//   ipd_allow_in      ring has room for a full packet
//   br_taken_cancel   flush request from ID
//   id_allow_in       ID accepts the head this cycle
//   ipd_to_id_valid   head entry valid
//   ipd_inst_type     one-hot type (addi.w at MSB ... ld.b at LSB)
//   ipd_pc, ipd_pred_pc, ipd_imm     head PC, predicted next PC, immediate
//   ipd_w_addr, ipd_r_addr1, ipd_r_addr2   register numbers (0 if unused)
//   ipd_occupancy     number of entries held
module ipd_ibuf_stage #(
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 8,
    parameter int TYPE_WD = 26
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      if_to_ipd_valid,
    input  logic [31:0]               if_pc,
    input  logic [31:0]               if_pred_pc,
    input  logic [32*FETCH_W-1:0]     if_inst,
    input  logic [FETCH_W-1:0]        if_slot_mask,
    output logic                      ipd_allow_in,
    input  logic                      br_taken_cancel,
    input  logic                      id_allow_in,
    output logic                      ipd_to_id_valid,
    output logic [TYPE_WD-1:0]        ipd_inst_type,
    output logic [31:0]               ipd_pc,
    output logic [31:0]               ipd_pred_pc,
    output logic [31:0]               ipd_imm,
    output logic [4:0]                ipd_w_addr,
    output logic [4:0]                ipd_r_addr1,
    output logic [4:0]                ipd_r_addr2,
    output logic [$clog2(DEPTH):0]    ipd_occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TYPE_WD-1:0] inst_type;
        logic [31:0]        pc;
        logic [31:0]        pred_pc;
        logic [31:0]        imm;
        logic [4:0]         w_addr;
        logic [4:0]         r_addr1;
        logic [4:0]         r_addr2;
    } entry_t;

    function automatic entry_t decode_slot(input logic [31:0] inst,
                                           input logic [31:0] pc,
                                           input logic [31:0] pred_pc);
        entry_t      e;
        logic [25:0] t;
        logic [16:0] op17;
        logic [9:0]  op10;
        logic [6:0]  op7;
        logic [5:0]  op6;
        logic        r3, ri, sb, wrd;
        op17 = inst[31:15];
        op10 = inst[31:22];
        op7  = inst[31:25];
        op6  = inst[31:26];
        t     = '0;
        t[25] = (op10 == 10'h00a);   // addi.w
        t[24] = (op17 == 17'h00020); // add.w
        t[23] = (op17 == 17'h00022); // sub.w
        t[22] = (op17 == 17'h0002a); // or
        t[21] = (op10 == 10'h00e);   // ori
        t[20] = (op17 == 17'h00028); // nor
        t[19] = (op10 == 10'h00d);   // andi
        t[18] = (op17 == 17'h00029); // and
        t[17] = (op17 == 17'h0002b); // xor
        t[16] = (op17 == 17'h00089); // srli.w
        t[15] = (op17 == 17'h00081); // slli.w
        t[14] = (op17 == 17'h00091); // srai.w
        t[13] = (op7  == 7'h0a);     // lu12i.w
        t[12] = (op7  == 7'h0e);     // pcaddu12i
        t[11] = (op17 == 17'h00024); // slt
        t[10] = (op17 == 17'h00025); // sltu
        t[9]  = (op17 == 17'h00038); // mul.w
        t[8]  = (op6  == 6'h13);     // jirl
        t[7]  = (op6  == 6'h14);     // b
        t[6]  = (op6  == 6'h16);     // beq
        t[5]  = (op6  == 6'h17);     // bne
        t[4]  = (op6  == 6'h15);     // bl
        t[3]  = (op10 == 10'h0a6);   // st.w
        t[2]  = (op10 == 10'h0a2);   // ld.w
        t[1]  = (op10 == 10'h0a4);   // st.b
        t[0]  = (op10 == 10'h0a0);   // ld.b

        r3  = t[24] | t[23] | t[22] | t[20] | t[18] | t[17] | t[11] | t[10] | t[9];
        ri  = t[25] | t[21] | t[19] | t[16] | t[15] | t[14] | t[8] | t[2] | t[0];
        sb  = t[6] | t[5] | t[3] | t[1];
        wrd = r3 | ri | t[13] | t[12];

        e.inst_type = TYPE_WD'(t);
        e.pc        = pc;
        e.pred_pc   = pred_pc;
        e.r_addr1   = r3 ? inst[14:10] : ((ri | sb) ? inst[9:5] : 5'd0);
        e.r_addr2   = r3 ? inst[9:5] : (sb ? inst[4:0] : 5'd0);
        e.w_addr    = wrd ? inst[4:0] : (t[4] ? 5'd1 : 5'd0);

        if (t[25] | t[3] | t[2] | t[1] | t[0])
            e.imm = {{20{inst[21]}}, inst[21:10]};
        else if (t[21] | t[19])
            e.imm = {20'd0, inst[21:10]};
        else if (t[16] | t[15] | t[14])
            e.imm = {27'd0, inst[14:10]};
        else if (t[13] | t[12])
            e.imm = {inst[24:5], 12'd0};
        else if (t[8] | t[6] | t[5])
            e.imm = {{14{inst[25]}}, inst[25:10], 2'b00};
        else if (t[7] | t[4])
            e.imm = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
        else
            e.imm = '0;
        return e;
    endfunction

    entry_t             mem [DEPTH];
    entry_t             dec [FETCH_W];
    entry_t             head;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   n_wr;
    logic [PTR_W-1:0]   slot_idx [FETCH_W];
    logic [FETCH_W-1:0] slot_wr;
    logic               enq, deq, buf_valid, skip;

    assign ipd_allow_in = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_W);
    assign enq          = if_to_ipd_valid & ipd_allow_in & ~br_taken_cancel;
    assign buf_valid    = (count != '0);
    assign deq          = buf_valid & id_allow_in & ~br_taken_cancel;
    assign head         = mem[rd_ptr];

    // Per-slot decode; the highest valid slot inherits the packet's predicted PC.
    always_comb begin
        int unsigned hi;
        hi = 0;
        for (int unsigned i = 0; i < FETCH_W; i++)
            if (if_slot_mask[i]) hi = i;
        for (int unsigned i = 0; i < FETCH_W; i++)
            dec[i] = decode_slot(if_inst[32*i +: 32], if_pc + 32'(4*i),
                                 (i == hi) ? if_pred_pc : if_pc + 32'(4*i + 4));
    end

`ifdef IPD_BYPASS_EN
    logic bypass;
    assign bypass = ~buf_valid & enq & if_slot_mask[0];
    // Slot 0 is consumed directly by ID and never occupies a ring entry.
    assign skip   = bypass & id_allow_in;
    always_comb begin
        ipd_to_id_valid = buf_valid | bypass;
        {ipd_inst_type, ipd_pc, ipd_pred_pc, ipd_imm,
         ipd_w_addr, ipd_r_addr1, ipd_r_addr2} = bypass ? dec[0] : head;
    end
`else
    assign skip = 1'b0;
    always_comb begin
        ipd_to_id_valid = buf_valid;
        {ipd_inst_type, ipd_pc, ipd_pred_pc, ipd_imm,
         ipd_w_addr, ipd_r_addr1, ipd_r_addr2} = head;
    end
`endif

    // Masked-in slots are compacted onto consecutive entries from wr_ptr.
    always_comb begin
        n_wr    = '0;
        slot_wr = '0;
        for (int unsigned i = 0; i < FETCH_W; i++) begin
            slot_idx[i] = wr_ptr + n_wr[PTR_W-1:0];
            slot_wr[i]  = enq & if_slot_mask[i] & ~(skip & (i == 0));
            if (slot_wr[i]) n_wr = n_wr + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < FETCH_W; i++)
            if (slot_wr[i]) mem[slot_idx[i]] <= dec[i];
    end

    always_ff @(posedge clk) begin
        if (reset || br_taken_cancel) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_wr[PTR_W-1:0];
            rd_ptr <= rd_ptr + PTR_W'(deq);
            count  <= count + n_wr - CNT_W'(deq);
        end
    end

    assign ipd_occupancy = count;

endmodule

// File: tb/tb_ipd_ibuf_stage.sv
// Testbench for ipd_ibuf_stage (default build, FETCH_W=2, DEPTH=8).
// Instructions are generated from (kind, fields) and the expected decode is
// derived from those fields; a queue models the buffer contents.
module tb_ipd_ibuf_stage;
    localparam int FW    = 2;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [25:0] ty;
        logic [31:0] pc;
        logic [31:0] pred;
        logic [31:0] imm;
        logic [4:0]  w;
        logic [4:0]  r1;
        logic [4:0]  r2;
    } exp_t;

    // instruction format classes
    localparam int C3R = 0, CSH = 1, CSI = 2, CST = 3, CU12 = 4, CU20 = 5,
                   CJIRL = 6, CBR = 7, CB26 = 8, CBAD = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_to_ipd_valid;
    logic [31:0]       if_pc, if_pred_pc;
    logic [32*FW-1:0]  if_inst;
    logic [FW-1:0]     if_slot_mask;
    logic              ipd_allow_in;
    logic              br_taken_cancel;
    logic              id_allow_in;
    logic              ipd_to_id_valid;
    logic [25:0]       ipd_inst_type;
    logic [31:0]       ipd_pc, ipd_pred_pc, ipd_imm;
    logic [4:0]        ipd_w_addr, ipd_r_addr1, ipd_r_addr2;
    logic [3:0]        ipd_occupancy;

    ipd_ibuf_stage #(.FETCH_W(FW), .DEPTH(DEPTH), .TYPE_WD(26)) dut (
        .clk(clk), .reset(reset),
        .if_to_ipd_valid(if_to_ipd_valid), .if_pc(if_pc), .if_pred_pc(if_pred_pc),
        .if_inst(if_inst), .if_slot_mask(if_slot_mask), .ipd_allow_in(ipd_allow_in),
        .br_taken_cancel(br_taken_cancel), .id_allow_in(id_allow_in),
        .ipd_to_id_valid(ipd_to_id_valid), .ipd_inst_type(ipd_inst_type),
        .ipd_pc(ipd_pc), .ipd_pred_pc(ipd_pred_pc), .ipd_imm(ipd_imm),
        .ipd_w_addr(ipd_w_addr), .ipd_r_addr1(ipd_r_addr1), .ipd_r_addr2(ipd_r_addr2),
        .ipd_occupancy(ipd_occupancy)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    exp_t  q[$];
    exp_t  pkt_exp [FW];
    bit    acc_last;
    bit    wrap_mode = 0;
    int    n_issued;
    logic [31:0] last_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int class_of(input int k);
        case (k)
            24, 23, 22, 20, 18, 17, 11, 10, 9: return C3R;
            16, 15, 14:  return CSH;
            25, 2, 0:    return CSI;
            3, 1:        return CST;
            21, 19:      return CU12;
            13, 12:      return CU20;
            8:           return CJIRL;
            6, 5:        return CBR;
            7, 4:        return CB26;
            default:     return CBAD;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input int k);
        case (k)
            25: return 32'h02800000;  24: return 32'h00100000;  23: return 32'h00110000;
            22: return 32'h00150000;  21: return 32'h03800000;  20: return 32'h00140000;
            19: return 32'h03400000;  18: return 32'h00148000;  17: return 32'h00158000;
            16: return 32'h00448000;  15: return 32'h00408000;  14: return 32'h00488000;
            13: return 32'h14000000;  12: return 32'h1c000000;  11: return 32'h00120000;
            10: return 32'h00128000;   9: return 32'h001c0000;   8: return 32'h4c000000;
             7: return 32'h50000000;   6: return 32'h58000000;   5: return 32'h5c000000;
             4: return 32'h54000000;   3: return 32'h29800000;   2: return 32'h28800000;
             1: return 32'h29000000;   0: return 32'h28000000;
            default: return 32'hffffffff;
        endcase
    endfunction

    // Place one instruction in slot s and record its expected decode.
    task automatic set_slot(input int s, input int k, input logic [4:0] rd,
                            input logic [4:0] rj, input logic [4:0] rk, input int f);
        logic [31:0] b, ins;
        exp_t e;
        int   c;
        c = class_of(k);
        b = base_of(k);
        e = '0;
        if (k < 26) e.ty = 26'(1) << k;
        case (c)
            C3R:  begin ins = b | (32'(rk) << 10) | (32'(rj) << 5) | 32'(rd);
                        e.r1 = rk; e.r2 = rj; e.w = rd; end
            CSH:  begin ins = b | (32'(f & 31) << 10) | (32'(rj) << 5) | 32'(rd);
                        e.r1 = rj; e.w = rd; e.imm = 32'(f); end
            CSI:  begin ins = b | (32'(f & 'hfff) << 10) | (32'(rj) << 5) | 32'(rd);
                        e.r1 = rj; e.w = rd; e.imm = 32'(f); end
            CST:  begin ins = b | (32'(f & 'hfff) << 10) | (32'(rj) << 5) | 32'(rd);
                        e.r1 = rj; e.r2 = rd; e.imm = 32'(f); end
            CU12: begin ins = b | (32'(f & 'hfff) << 10) | (32'(rj) << 5) | 32'(rd);
                        e.r1 = rj; e.w = rd; e.imm = 32'(f); end
            CU20: begin ins = b | (32'(f & 'hfffff) << 5) | 32'(rd);
                        e.w = rd; e.imm = 32'(f) << 12; end
            CJIRL: begin ins = b | (32'(f & 'hffff) << 10) | (32'(rj) << 5) | 32'(rd);
                        e.r1 = rj; e.w = rd; e.imm = 32'(f * 4); end
            CBR:  begin ins = b | (32'(f & 'hffff) << 10) | (32'(rj) << 5) | 32'(rd);
                        e.r1 = rj; e.r2 = rd; e.imm = 32'(f * 4); end
            CB26: begin ins = b | (32'(f & 'hffff) << 10) | 32'((f >>> 16) & 'h3ff);
                        e.imm = 32'(f * 4); if (k == 4) e.w = 5'd1; end
            default: ins = 32'hffffffff;
        endcase
        if_inst[32*s +: 32] = ins;
        pkt_exp[s] = e;
    endtask

    task automatic rand_slot(input int s);
        int k, c, f;
        k = int'($urandom_range(0, 26));
        c = class_of(k);
        case (c)
            CSH:          f = int'($urandom_range(0, 31));
            CSI, CST:     f = int'($urandom_range(0, 4095)) - 2048;
            CU12:         f = int'($urandom_range(0, 4095));
            CU20:         f = int'($urandom_range(0, 'hfffff));
            CJIRL, CBR:   f = int'($urandom_range(0, 65535)) - 32768;
            CB26:         f = int'($urandom_range(0, (1 << 26) - 1)) - (1 << 25);
            default:      f = 0;
        endcase
        set_slot(s, k, 5'($urandom), 5'($urandom), 5'($urandom), f);
    endtask

    task automatic check_all();
        chk("valid", 32'(ipd_to_id_valid), 32'(q.size() != 0));
        chk("occupancy", 32'(ipd_occupancy), 32'(q.size()));
        chk("allow_in", 32'(ipd_allow_in), 32'((DEPTH - q.size()) >= FW));
        if (q.size() != 0) begin
            chk("inst_type", 32'(ipd_inst_type), 32'(q[0].ty));
            chk("pc", ipd_pc, q[0].pc);
            chk("pred_pc", ipd_pred_pc, q[0].pred);
            chk("imm", ipd_imm, q[0].imm);
            chk("w_addr", 32'(ipd_w_addr), 32'(q[0].w));
            chk("r_addr1", 32'(ipd_r_addr1), 32'(q[0].r1));
            chk("r_addr2", 32'(ipd_r_addr2), 32'(q[0].r2));
        end
    endtask

    // Advance one clock: update the model from the driven inputs, then check
    // the DUT at the following falling edge.
    task automatic step();
        int   hi;
        exp_t e;
        if (wrap_mode && ipd_to_id_valid && id_allow_in && !br_taken_cancel) begin
            if (n_issued > 0) chk("wrap_pc_step", ipd_pc, last_pc + 32'd4);
            last_pc = ipd_pc;
            n_issued++;
        end
        acc_last = 0;
        if (reset || br_taken_cancel) begin
            q.delete();
        end else begin
            acc_last = if_to_ipd_valid && ((DEPTH - q.size()) >= FW);
            if (q.size() > 0 && id_allow_in) void'(q.pop_front());
            if (acc_last) begin
                hi = -1;
                for (int i = 0; i < FW; i++) if (if_slot_mask[i]) hi = i;
                for (int i = 0; i < FW; i++) begin
                    if (if_slot_mask[i]) begin
                        e      = pkt_exp[i];
                        e.pc   = if_pc + 32'(4 * i);
                        e.pred = (i == hi) ? if_pred_pc : e.pc + 32'd4;
                        q.push_back(e);
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drain();
        int g;
        if_to_ipd_valid = 0;
        br_taken_cancel = 0;
        id_allow_in = 1;
        g = 0;
        while (q.size() > 0 && g < 40) begin
            step();
            g++;
        end
        chk("drain_empty", 32'(ipd_occupancy), 32'd0);
    endtask

    initial begin
        int g;
        reset = 1; if_to_ipd_valid = 0; if_pc = '0; if_pred_pc = '0; if_inst = '0;
        if_slot_mask = '0; br_taken_cancel = 0; id_allow_in = 0;
        for (int s = 0; s < FW; s++) set_slot(s, 24, 0, 0, 0, 0);
        step();
        step();
        reset = 0;

        // add.w r3,r1,r2 / addi.w r4,r1,-1
        set_slot(0, 24, 5'd3, 5'd1, 5'd2, 0);
        set_slot(1, 25, 5'd4, 5'd1, 5'd0, -1);
        if_pc = 32'h1c000000; if_pred_pc = 32'h1c001000; if_slot_mask = 2'b11;
        if_to_ipd_valid = 1; id_allow_in = 1;
        step();
        if_to_ipd_valid = 0;
        chk("t1_type_add", 32'(ipd_inst_type), 32'h01000000);
        chk("t1_r1", 32'(ipd_r_addr1), 32'd2);
        chk("t1_r2", 32'(ipd_r_addr2), 32'd1);
        chk("t1_w", 32'(ipd_w_addr), 32'd3);
        step();
        chk("t1_pc2", ipd_pc, 32'h1c000004);
        chk("t1_imm2", ipd_imm, 32'hffffffff);
        chk("t1_pred2", ipd_pred_pc, 32'h1c001000);
        drain();

        // fill to DEPTH with ID stalled
        id_allow_in = 0;
        for (int p = 0; p < 5; p++) begin
            rand_slot(0); rand_slot(1);
            if_pc = 32'h00400000 + 32'(8 * p); if_pred_pc = if_pc + 32'd8;
            if_slot_mask = 2'b11; if_to_ipd_valid = 1;
            step();
            if (p == 3) begin
                chk("full_occ", 32'(ipd_occupancy), 32'd8);
                chk("full_allow", 32'(ipd_allow_in), 32'd0);
            end
        end
        chk("held_occ", 32'(ipd_occupancy), 32'd8);
        id_allow_in = 1;
        step();
        chk("deq1_occ", 32'(ipd_occupancy), 32'd7);
        chk("deq1_allow", 32'(ipd_allow_in), 32'd0);
        step();
        chk("deq2_occ", 32'(ipd_occupancy), 32'd6);
        chk("deq2_allow", 32'(ipd_allow_in), 32'd1);
        id_allow_in = 0;
        step();
        chk("refill_occ", 32'(ipd_occupancy), 32'd8);
        drain();

        // flush with a same-cycle packet
        id_allow_in = 0;
        for (int p = 0; p < 3; p++) begin
            rand_slot(0); rand_slot(1);
            if_pc = 32'h00800000 + 32'(8 * p); if_pred_pc = 32'h00900000;
            if_slot_mask = (p == 2) ? 2'b01 : 2'b11; if_to_ipd_valid = 1;
            step();
        end
        chk("pre_cancel_occ", 32'(ipd_occupancy), 32'd5);
        rand_slot(0); rand_slot(1);
        if_pc = 32'h0bad0000; if_slot_mask = 2'b11; br_taken_cancel = 1; id_allow_in = 1;
        step();
        br_taken_cancel = 0; if_to_ipd_valid = 0;
        chk("cancel_occ", 32'(ipd_occupancy), 32'd0);
        chk("cancel_valid", 32'(ipd_to_id_valid), 32'd0);
        step();
        step();

        // beq r5,r6,-4 / bl 1
        set_slot(0, 6, 5'd6, 5'd5, 5'd0, -4);
        set_slot(1, 4, 5'd0, 5'd0, 5'd0, 1);
        if_pc = 32'h1c000100; if_pred_pc = 32'h1c000200; if_slot_mask = 2'b11;
        if_to_ipd_valid = 1; id_allow_in = 1;
        step();
        if_to_ipd_valid = 0;
        chk("beq_r1", 32'(ipd_r_addr1), 32'd5);
        chk("beq_r2", 32'(ipd_r_addr2), 32'd6);
        chk("beq_imm", ipd_imm, 32'hfffffff0);
        step();
        chk("bl_w", 32'(ipd_w_addr), 32'd1);
        chk("bl_imm", ipd_imm, 32'd4);
        drain();

        // unrecognised opcode
        set_slot(0, 26, 0, 0, 0, 0);
        rand_slot(1);
        if_pc = 32'h1c000300; if_pred_pc = 32'h1c000400; if_slot_mask = 2'b01;
        if_to_ipd_valid = 1; id_allow_in = 0;
        step();
        if_to_ipd_valid = 0;
        chk("bad_type", 32'(ipd_inst_type), 32'd0);
        chk("bad_imm", ipd_imm, 32'd0);
        chk("bad_regs", 32'({ipd_w_addr, ipd_r_addr1, ipd_r_addr2}), 32'd0);
        id_allow_in = 1;
        step();
        chk("bad_once", 32'(ipd_to_id_valid), 32'd0);

        // wrap: 20 packets, alternating id_allow_in
        wrap_mode = 1; n_issued = 0;
        for (int p = 0; p < 20; p++) begin
            rand_slot(0); rand_slot(1);
            if_pc = 32'h20000000 + 32'(8 * p); if_pred_pc = if_pc + 32'd8;
            if_slot_mask = 2'b11; if_to_ipd_valid = 1;
            g = 0;
            do begin
                id_allow_in = ~id_allow_in;
                step();
                g++;
            end while (!acc_last && g < 20);
            if (!acc_last) chk("wrap_accept_timeout", 32'(ipd_allow_in), 32'd1);
        end
        drain();
        wrap_mode = 0;
        chk("wrap_issued", 32'(n_issued), 32'd40);
        chk("wrap_last_pc", last_pc, 32'h20000000 + 32'd156);

        // random traffic, including mask=0 packets, flushes and a mid-run reset
        for (int c = 0; c < 300; c++) begin
            rand_slot(0); rand_slot(1);
            if_pc = $urandom & 32'hfffffffc; if_pred_pc = $urandom & 32'hfffffffc;
            if_slot_mask = FW'($urandom_range(0, 3));
            if_to_ipd_valid = ($urandom_range(0, 3) != 0);
            id_allow_in = ($urandom_range(0, 2) != 0);
            br_taken_cancel = ($urandom_range(0, 24) == 0);
            reset = (c == 150);
            step();
        end
        reset = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
